// File: rtl/iter_mul_if.sv
// Operand/product handshake bundle for iter_mul: operands in via in_valid/in_ready,
// product out via out_valid/out_ready.
interface iter_mul_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               in_valid;
  logic               mul_signed;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output x, y, in_valid, mul_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  x, y, in_valid, mul_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, full 2*WIDTH product; latency WIDTH+1.
// Optional MUL_EARLY_OUT_EN: leave BUSY once the remaining multiplier bits are all zero.
module iter_mul #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  iter_mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mreg_q, mreg_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic               last_iter;
  logic               skip;
  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;

  assign accept    = bus.in_valid & (state_q == IDLE);
  assign last_iter = (count_q == CW'(WIDTH - 1));

`ifdef MUL_EARLY_OUT_EN
  assign skip = (mreg_q == '0);
`else
  assign skip = 1'b0;
`endif

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
  assign x_mag = (bus.mul_signed & bus.x[WIDTH-1]) ? (~bus.x + WIDTH'(1)) : bus.x;
  assign y_mag = (bus.mul_signed & bus.y[WIDTH-1]) ? (~bus.y + WIDTH'(1)) : bus.y;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (skip || last_iter) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.p         = p_q;
  end

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mreg_d  = mreg_q;
    count_d = count_q;
    neg_d   = neg_q;
    p_d     = p_q;
    if (accept) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, x_mag};
      mreg_d  = y_mag;
      count_d = '0;
      neg_d   = bus.mul_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
    end else if ((state_q == BUSY) && !skip) begin
      if (mreg_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mreg_d  = mreg_q >> 1;
      count_d = count_q + CW'(1);
    end else if (state_q == FIX) begin
      // a zero magnitude negates to zero, so no special case for negative zero
      p_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mreg_q  <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mreg_q  <= mreg_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
    end
  end
endmodule
